// File: rtl/vga_pkg.sv
// Shared VGA timing constant sets and total-computation helpers.
package vga_pkg;

  typedef struct packed {
    int unsigned visible;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_timing_t;

  localparam axis_timing_t VGA640_H = '{visible: 640, front: 16, sync: 64,  back: 120};
  localparam axis_timing_t VGA640_V = '{visible: 480, front: 1,  sync: 3,   back: 16};
  localparam axis_timing_t VGA800_H = '{visible: 800, front: 40, sync: 128, back: 88};
  localparam axis_timing_t VGA800_V = '{visible: 600, front: 1,  sync: 4,   back: 23};

  function automatic int unsigned axis_total(input int unsigned visible, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return visible + front + sync + back;
  endfunction

  localparam int unsigned VGA640_H_TOTAL = axis_total(640, 16, 64, 120);
  localparam int unsigned VGA640_V_TOTAL = axis_total(480, 1, 3, 16);
  localparam int unsigned VGA800_H_TOTAL = axis_total(800, 40, 128, 88);
  localparam int unsigned VGA800_V_TOTAL = axis_total(600, 1, 4, 23);

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-MAX position counter for one screen axis; wrap flags the increment that returns to 0.
module vga_axis_counter #(
  parameter int unsigned MAX = 2,
  parameter int          W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count_q, count_d;

  assign wrap  = inc && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear || wrap) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing: address stage (posX/posY) plus a registered output stage
// one ce-cycle behind it, matching a one-cycle-latency pixel source.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA640_H.visible,
  parameter int unsigned H_FRONT    = VGA640_H.front,
  parameter int unsigned H_SYNC     = VGA640_H.sync,
  parameter int unsigned H_BACK     = VGA640_H.back,
  parameter int unsigned V_VISIBLE  = VGA640_V.visible,
  parameter int unsigned V_FRONT    = VGA640_V.front,
  parameter int unsigned V_SYNC     = VGA640_V.sync,
  parameter int unsigned V_BACK     = VGA640_V.back,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int          PIX_W      = 3,
  parameter int          CNT_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [PIX_W-1:0] pixelIn,
  output logic [PIX_W-1:0] pixelOut,
  output logic             Hsync,
  output logic             Vsync,
  output logic             de,
  output logic [CNT_W-1:0] posX,
  output logic [CNT_W-1:0] posY,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned     H_TOTAL   = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned     V_TOTAL   = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      PIX_W < 1 || CNT_W < 1 || CNT_W > 32 ||
      CNT_RANGE <= 64'(H_TOTAL) || CNT_RANGE <= 64'(V_TOTAL)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameters or CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] cnt_x, cnt_y;
  logic             x_wrap, y_wrap;

  vga_axis_counter #(.MAX(H_TOTAL), .W(CNT_W)) u_x_cnt (
    .clk(clk), .rst(rst), .inc(ce), .clear(1'b0), .count(cnt_x), .wrap(x_wrap)
  );

  vga_axis_counter #(.MAX(V_TOTAL), .W(CNT_W)) u_y_cnt (
    .clk(clk), .rst(rst), .inc(x_wrap && ce), .clear(1'b0), .count(cnt_y), .wrap(y_wrap)
  );

  assign posX = cnt_x;
  assign posY = cnt_y;

  logic vis, hs_act, vs_act;
  assign vis    = (cnt_x < X_VIS) && (cnt_y < Y_VIS);
  assign hs_act = (cnt_x >= HS_START) && (cnt_x < HS_END);
  assign vs_act = (cnt_y >= VS_START) && (cnt_y < VS_END);

  logic [PIX_W-1:0] pix_q, pix_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, ls_q, ls_d, fs_q, fs_d;
  // home_q is set exactly while the counters sit at (0,0): after reset or a frame wrap.
  logic home_q, home_d;

  always_comb begin
    pix_d  = pix_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    home_d = home_q;
    if (ce) begin
      de_d   = vis;
      pix_d  = vis ? pixelIn : '0;
      hs_d   = hs_act ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d   = vs_act ? V_SYNC_POL : ~V_SYNC_POL;
      ls_d   = (cnt_x == '0);
      fs_d   = home_q;
      home_d = y_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= ~H_SYNC_POL;
      vs_q   <= ~V_SYNC_POL;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      home_q <= 1'b1;
    end else begin
      pix_q  <= pix_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      home_q <= home_d;
    end
  end

  assign pixelOut    = pix_q;
  assign de          = de_q;
  assign Hsync       = hs_q;
  assign Vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (active-low and active-high sync)
// driven with one stimulus, each checked against an arithmetic screen-position model.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst, ce;
  logic [2:0] pix_a;
  logic [3:0] pix_b;

  logic [2:0] pixelOut_a;
  logic [3:0] pixelOut_b;
  logic       Hsync_a, Vsync_a, de_a, ls_a, fs_a;
  logic       Hsync_b, Vsync_b, de_b, ls_b, fs_b;
  logic [4:0] posX_a, posY_a;
  logic [3:0] posX_b, posY_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIX_W(3), .CNT_W(5)
  ) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .pixelIn(pix_a), .pixelOut(pixelOut_a),
    .Hsync(Hsync_a), .Vsync(Vsync_a), .de(de_a), .posX(posX_a), .posY(posY_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(5), .H_FRONT(1), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_W(4), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .pixelIn(pix_b), .pixelOut(pixelOut_b),
    .Hsync(Hsync_b), .Vsync(Vsync_b), .de(de_b), .posX(posX_b), .posY(posY_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int p_hv[2] = '{8, 5};
  int p_hf[2] = '{2, 1};
  int p_hs[2] = '{3, 2};
  int p_hb[2] = '{4, 2};
  int p_vv[2] = '{6, 3};
  int p_vf[2] = '{1, 1};
  int p_vs[2] = '{2, 1};
  int p_vb[2] = '{2, 1};
  int p_pol[2] = '{0, 1};

  int n[2];  // ce-cycles taken since the last reset
  int e_de[2], e_pix[2], e_hs[2], e_vs[2], e_ls[2], e_fs[2];

  int compared = 0;
  int mismatched = 0;

  function automatic int ht(input int d);
    return p_hv[d] + p_hf[d] + p_hs[d] + p_hb[d];
  endfunction

  function automatic int vt(input int d);
    return p_vv[d] + p_vf[d] + p_vs[d] + p_vb[d];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d, input bit r, input bit c, input int pix);
    int x, y;
    if (!r) begin
      n[d] = 0; e_de[d] = 0; e_pix[d] = 0;
      e_hs[d] = 1 - p_pol[d]; e_vs[d] = 1 - p_pol[d];
      e_ls[d] = 0; e_fs[d] = 0;
    end else if (c) begin
      x = n[d] % ht(d);
      y = (n[d] / ht(d)) % vt(d);
      e_de[d]  = (x < p_hv[d] && y < p_vv[d]) ? 1 : 0;
      e_pix[d] = e_de[d] ? pix : 0;
      e_hs[d]  = (x >= p_hv[d] + p_hf[d] && x < p_hv[d] + p_hf[d] + p_hs[d]) ? p_pol[d] : 1 - p_pol[d];
      e_vs[d]  = (y >= p_vv[d] + p_vf[d] && y < p_vv[d] + p_vf[d] + p_vs[d]) ? p_pol[d] : 1 - p_pol[d];
      e_ls[d]  = (x == 0) ? 1 : 0;
      e_fs[d]  = (x == 0 && y == 0) ? 1 : 0;
      n[d]++;
    end else begin
      e_ls[d] = 0;
      e_fs[d] = 0;
    end
  endtask

  task automatic check_all();
    chk("A.posX", 32'(posX_a), n[0] % ht(0));
    chk("A.posY", 32'(posY_a), (n[0] / ht(0)) % vt(0));
    chk("A.de", 32'(de_a), e_de[0]);
    chk("A.pixelOut", 32'(pixelOut_a), e_pix[0]);
    chk("A.Hsync", 32'(Hsync_a), e_hs[0]);
    chk("A.Vsync", 32'(Vsync_a), e_vs[0]);
    chk("A.line_start", 32'(ls_a), e_ls[0]);
    chk("A.frame_start", 32'(fs_a), e_fs[0]);
    chk("B.posX", 32'(posX_b), n[1] % ht(1));
    chk("B.posY", 32'(posY_b), (n[1] / ht(1)) % vt(1));
    chk("B.de", 32'(de_b), e_de[1]);
    chk("B.pixelOut", 32'(pixelOut_b), e_pix[1]);
    chk("B.Hsync", 32'(Hsync_b), e_hs[1]);
    chk("B.Vsync", 32'(Vsync_b), e_vs[1]);
    chk("B.line_start", 32'(ls_b), e_ls[1]);
    chk("B.frame_start", 32'(fs_b), e_fs[1]);
  endtask

  // Drive one clk of stimulus, advance the model at the edge, check 1 time unit later.
  task automatic step(input bit r, input bit c, input int pa, input int pb);
    rst = r; ce = c;
    pix_a = 3'(pa); pix_b = 4'(pb);
    @(posedge clk);
    model_edge(0, r, c, int'(pix_a));
    model_edge(1, r, c, int'(pix_b));
    #1;
    check_all();
  endtask

  int hs_low_a, vs_low_a, de_hi_a, fs_cnt_a, ls_cnt_a;
  int hs_hi_b, vs_hi_b, de_hi_b, fs_cnt_b;

  initial begin
    rst = 1'b0; ce = 1'b0; pix_a = '0; pix_b = '0;
    hs_low_a = 0; vs_low_a = 0; de_hi_a = 0; fs_cnt_a = 0; ls_cnt_a = 0;
    hs_hi_b = 0; vs_hi_b = 0; de_hi_b = 0; fs_cnt_b = 0;

    // Reset is honoured with and without ce.
    for (int i = 0; i < 3; i++) step(1'b0, i[0], $urandom, $urandom);
    chk("rst.de_a", 32'(de_a), 0);
    chk("rst.Hsync_a", 32'(Hsync_a), 1);
    chk("rst.Hsync_b", 32'(Hsync_b), 0);
    chk("rst.Vsync_b", 32'(Vsync_b), 0);

    // One full frame of A with ce=1; pixelIn all ones outside the first pixel.
    for (int i = 0; i < 187; i++) begin
      step(1'b1, 1'b1, (i == 0) ? 5 : 7, (i == 0) ? 10 : 15);
      if (i == 0) begin
        chk("first.de_a", 32'(de_a), 1);
        chk("first.pixelOut_a", 32'(pixelOut_a), 5);
        chk("first.line_start_a", 32'(ls_a), 1);
        chk("first.frame_start_a", 32'(fs_a), 1);
        chk("first.posX_a", 32'(posX_a), 1);
        chk("first.posY_a", 32'(posY_a), 0);
        chk("first.pixelOut_b", 32'(pixelOut_b), 10);
      end
      hs_low_a += (Hsync_a == 1'b0) ? 1 : 0;
      vs_low_a += (Vsync_a == 1'b0) ? 1 : 0;
      de_hi_a  += de_a ? 1 : 0;
      fs_cnt_a += fs_a ? 1 : 0;
      ls_cnt_a += ls_a ? 1 : 0;
      if (i < 60) begin
        hs_hi_b  += Hsync_b ? 1 : 0;
        vs_hi_b  += Vsync_b ? 1 : 0;
        de_hi_b  += de_b ? 1 : 0;
        fs_cnt_b += fs_b ? 1 : 0;
      end
    end
    chk("frame.hs_low_a", hs_low_a, 3 * 11);
    chk("frame.vs_low_a", vs_low_a, 2 * 17);
    chk("frame.de_hi_a", de_hi_a, 8 * 6);
    chk("frame.fs_cnt_a", fs_cnt_a, 1);
    chk("frame.ls_cnt_a", ls_cnt_a, 11);
    chk("frame.hs_hi_b", hs_hi_b, 2 * 6);
    chk("frame.vs_hi_b", vs_hi_b, 1 * 10);
    chk("frame.de_hi_b", de_hi_b, 5 * 3);
    chk("frame.fs_cnt_b", fs_cnt_b, 1);

    // ce alternating 1,0,... then random ce.
    for (int i = 0; i < 400; i++)
      step(1'b1, (i < 100) ? ~i[0] : ($urandom_range(1, 0) == 1), $urandom, $urandom);

    // Run A to (5,3), then reset for a single clk.
    for (int k = 0; k < 400 && !((n[0] % 17 == 5) && ((n[0] / 17) % 11 == 3)); k++)
      step(1'b1, 1'b1, $urandom, $urandom);
    chk("mid.posX_a_before", 32'(posX_a), 5);
    chk("mid.posY_a_before", 32'(posY_a), 3);
    step(1'b0, ($urandom_range(1, 0) == 1), $urandom, $urandom);
    chk("mid.posX_a", 32'(posX_a), 0);
    chk("mid.posY_a", 32'(posY_a), 0);
    chk("mid.Hsync_a", 32'(Hsync_a), 1);
    chk("mid.Vsync_a", 32'(Vsync_a), 1);
    chk("mid.de_a", 32'(de_a), 0);

    // Random ce, pixels and occasional resets.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(99, 0) != 0), ($urandom_range(3, 0) != 0), $urandom, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
